// File: rtl/sym_packer_pkg.sv
// Shared helpers for the symbol packer and its FIFO: pointer sizing, default width,
// and the Gray encoder used when GRAY_MAP_EN is defined.
package sym_packer_pkg;

    localparam int MAX_W_DEFAULT = 16;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Gray code restricted to the low w bits; everything above stays zero.
    function automatic logic [31:0] gray_encode(input logic [31:0] s, input int w);
        logic [31:0] m;
        m = (w >= 32) ? 32'hFFFF_FFFF : ~(32'hFFFF_FFFF << w);
        return (s ^ (s >> 1)) & m;
    endfunction

endpackage

// File: rtl/sync_fifo_reg.sv
// Synchronous FIFO with a registered head output and an occupancy count.
// dout always holds the current head entry, so a consumer sees data with sym_valid.
module sync_fifo_reg
    import sym_packer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = ptr_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wp, r_rp;
    logic [PW:0]      r_cnt;
    logic [WIDTH-1:0] r_dout;
    logic             w_push, w_pop;
    logic [PW-1:0]    w_rp_nxt;

    assign w_push   = wr_en && (r_cnt != (PW+1)'(DEPTH));
    assign w_pop    = rd_en && (r_cnt != '0);
    assign w_rp_nxt = r_rp + 1'b1;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            r_dout <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= w_rp_nxt;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            // Head register: next stored entry, the bypassed write, or empty.
            if (w_pop) begin
                if (r_cnt > (PW+1)'(1)) r_dout <= r_mem[w_rp_nxt];
                else if (w_push)        r_dout <= din;
                else                    r_dout <= '0;
            end else if (w_push && (r_cnt == '0)) begin
                r_dout <= din;
            end
        end
    end

    assign dout  = r_dout;
    assign valid = (r_cnt != '0);
    assign count = r_cnt;

endmodule

// File: rtl/sym_packer.sv
// Packs a serial bit stream into run-time-width symbols, buffered in a small FIFO.
// Define GRAY_MAP_EN to Gray-encode each completed symbol before it is stored.
module sym_packer
    import sym_packer_pkg::*;
#(
    parameter int MAX_W = MAX_W_DEFAULT,
    parameter int CFG_W = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       bit_valid,
    input  logic                       bit_in,
    output logic                       bit_ready,
    input  logic [CFG_W-1:0]           width_cfg,
    input  logic                       msb_first,
    output logic                       sym_valid,
    input  logic                       sym_ready,
    output logic [MAX_W-1:0]           sym_data,
    output logic                       overrun,
    output logic [$clog2(DEPTH):0]     fill
);
    logic             r_rdy_en, r_msb, r_ovr;
    logic [CFG_W-1:0] r_cnt, r_cfg;
    logic [MAX_W-1:0] r_acc;

    logic             w_full, w_fire, w_msb, w_last, w_push;
    logic [CFG_W-1:0] w_cfg;
    logic [MAX_W-1:0] w_acc_nxt, w_mask, w_sym;

    assign w_full    = (fill == ($clog2(DEPTH)+1)'(DEPTH));
    assign bit_ready = r_rdy_en && !w_full;
    assign w_fire    = bit_valid && bit_ready;

    // The first bit of a symbol uses the live config, which is latched on that same edge.
    assign w_cfg  = (r_cnt == '0) ? width_cfg : r_cfg;
    assign w_msb  = (r_cnt == '0) ? msb_first : r_msb;
    assign w_last = (r_cnt == w_cfg);
    assign w_push = w_fire && w_last;
    assign w_mask = ~({MAX_W{1'b1}} << (int'(w_cfg) + 1));

    always_comb begin
        w_acc_nxt = r_acc;
        if (w_msb) w_acc_nxt = {r_acc[MAX_W-2:0], bit_in};
        else       w_acc_nxt = r_acc | (MAX_W'(bit_in) << r_cnt);
    end

`ifdef GRAY_MAP_EN
    logic [31:0] w_g32;
    assign w_g32 = gray_encode(32'(w_acc_nxt & w_mask), int'(w_cfg) + 1);
    assign w_sym = w_g32[MAX_W-1:0];
`else
    assign w_sym = w_acc_nxt & w_mask;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdy_en <= 1'b0;
            r_ovr    <= 1'b0;
            r_cnt    <= '0;
            r_cfg    <= '0;
            r_msb    <= 1'b0;
            r_acc    <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            // Only a full FIFO stalls the source outside reset.
            if (bit_valid && r_rdy_en && w_full) r_ovr <= 1'b1;
            if (w_fire) begin
                if (r_cnt == '0) begin
                    r_cfg <= width_cfg;
                    r_msb <= msb_first;
                end
                if (w_last) begin
                    r_cnt <= '0;
                    r_acc <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                    r_acc <= w_acc_nxt;
                end
            end
        end
    end

    assign overrun = r_ovr;

    sync_fifo_reg #(.WIDTH(MAX_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (w_push),
        .din   (w_sym),
        .rd_en (sym_ready),
        .dout  (sym_data),
        .valid (sym_valid),
        .count (fill)
    );

endmodule

// File: tb/tb_sym_packer.sv
// Directed bench for sym_packer: a queue-based model of bits, symbols and FIFO
// is compared against the DUT every cycle, with literal checks pinning key results.
module tb_sym_packer;
    localparam int MAX_W = 16;
    localparam int CFG_W = 4;
    localparam int DEPTH = 4;
`ifdef GRAY_MAP_EN
    localparam bit GRAY = 1'b1;
`else
    localparam bit GRAY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, bit_valid, bit_in, msb_first, sym_ready;
    logic [CFG_W-1:0] width_cfg;
    logic bit_ready, sym_valid, overrun;
    logic [MAX_W-1:0] sym_data;
    logic [$clog2(DEPTH):0] fill;

    always #5 clk = ~clk;

    sym_packer #(.MAX_W(MAX_W), .CFG_W(CFG_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in),
        .bit_ready(bit_ready), .width_cfg(width_cfg), .msb_first(msb_first),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_data(sym_data),
        .overrun(overrun), .fill(fill)
    );

    int m_q[$];
    bit m_bits[$];
    int m_log[$];
    int m_w = 1;
    bit m_msb = 1'b0, m_en = 1'b0, m_ovr = 1'b0, m_zero = 1'b1;
    int n_cmp = 0, n_fail = 0;

    function automatic bit m_ready();
        return m_en && (m_q.size() < DEPTH);
    endfunction

    function automatic int sym_of(input bit b[$], input int w, input bit msb);
        int v;
        v = 0;
        for (int i = 0; i < w; i++) begin
            if (b[i]) v = v + (msb ? (1 << (w - 1 - i)) : (1 << i));
        end
        if (GRAY) v = v ^ (v >> 1);
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_bits.delete();
            m_en   = 1'b0;
            m_ovr  = 1'b0;
            m_zero = 1'b1;
        end else begin
            bit rdy;
            rdy = m_ready();
            if (bit_valid && m_en && !rdy) m_ovr = 1'b1;
            if ((m_q.size() > 0) && sym_ready) m_log.push_back(m_q.pop_front());
            if (bit_valid && rdy) begin
                if (m_bits.size() == 0) begin
                    m_w   = int'(width_cfg) + 1;
                    m_msb = msb_first;
                end
                m_bits.push_back(bit_in);
                if (m_bits.size() == m_w) begin
                    m_q.push_back(sym_of(m_bits, m_w, m_msb));
                    m_bits.delete();
                    m_zero = 1'b0;
                end
            end
            m_en = 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("bit_ready", 32'(bit_ready), 32'(m_ready()));
        chk("sym_valid", 32'(sym_valid), 32'(m_q.size() > 0));
        chk("fill", 32'(fill), 32'(m_q.size()));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        if (m_q.size() > 0) chk("sym_data", 32'(sym_data), 32'(m_q[0]));
        else if (m_zero)    chk("sym_data_zero", 32'(sym_data), 32'd0);
    endtask

    task automatic send(input bit b);
        bit_valid = 1'b1;
        bit_in    = b;
        for (int k = 0; k < 40; k++) begin
            bit a;
            a = m_ready();
            tick();
            if (a) return;
        end
        chk("accept_timeout", 32'd0, 32'd1);
    endtask

    // Bits go out first = v[n-1] down to v[0].
    task automatic send_vec(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send(v[i]);
        bit_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit_valid = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b1; bit_valid = 1'b1; bit_in = 1'b1; sym_ready = 1'b0;
        width_cfg = 4'd3; msb_first = 1'b1;
        repeat (5) tick();
        chk("rst_ready", 32'(bit_ready), 32'd0);
        chk("rst_fill", 32'(fill), 32'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", 32'(bit_ready), 32'd1);
        chk("ovr_after_rst", 32'(overrun), 32'd0);
        idle(1);

        // MSB-first, 4 bits 1,0,1,1
        sym_ready = 1'b1;
        send_vec(32'b1011, 4);
        chk("msb_valid", 32'(sym_valid), 32'd1);
        chk("msb_sym", 32'(sym_data), GRAY ? 32'hE : 32'hB);
        tick();
        chk("msb_held_one", 32'(sym_valid), 32'd0);

        // LSB-first, then W=1
        base = m_log.size();
        msb_first = 1'b0;
        send_vec(32'b1011, 4);
        width_cfg = 4'd0;
        send_vec(32'b10, 2);
        idle(3);
        chk("lsb_sym", 32'(m_log[base]), GRAY ? 32'hB : 32'hD);
        chk("w1_sym0", 32'(m_log[base+1]), 32'h1);
        chk("w1_sym1", 32'(m_log[base+2]), 32'h0);

        // Backpressure with W=2
        base = m_log.size();
        sym_ready = 1'b0; width_cfg = 4'd1; msb_first = 1'b1;
        send_vec(32'b10011100, 8);
        chk("bp_fill", 32'(fill), 32'd4);
        chk("bp_ready", 32'(bit_ready), 32'd0);
        bit_valid = 1'b1; bit_in = 1'b1;
        tick(); tick();
        chk("bp_overrun", 32'(overrun), 32'd1);
        sym_ready = 1'b1;
        send(1'b1);
        send(1'b0);
        idle(6);
        chk("bp_s0", 32'(m_log[base]),   GRAY ? 32'h3 : 32'h2);
        chk("bp_s1", 32'(m_log[base+1]), 32'h1);
        chk("bp_s2", 32'(m_log[base+2]), GRAY ? 32'h2 : 32'h3);
        chk("bp_s3", 32'(m_log[base+3]), 32'h0);
        chk("bp_s4", 32'(m_log[base+4]), GRAY ? 32'h3 : 32'h2);

        // Config change mid-symbol
        base = m_log.size();
        width_cfg = 4'd3; msb_first = 1'b1;
        send(1'b1); send(1'b1);
        width_cfg = 4'd7;
        send(1'b0); send(1'b1);
        chk("mid_valid4", 32'(sym_valid), 32'd1);
        chk("mid_sym4", 32'(sym_data), GRAY ? 32'hB : 32'hD);
        send_vec(32'b1010010, 7);
        chk("mid_no_early", 32'(sym_valid), 32'd0);
        send_vec(32'b1, 1);
        chk("mid_valid8", 32'(sym_valid), 32'd1);
        chk("mid_sym8", 32'(sym_data), GRAY ? 32'hF7 : 32'hA5);
        idle(2);
        chk("mid_log", 32'(m_log[base]), GRAY ? 32'hB : 32'hD);

        // Full width, LSB-first
        width_cfg = 4'd15; msb_first = 1'b0;
        send_vec(32'hC001, 16);
        chk("w16_sym", 32'(sym_data), GRAY ? 32'hC002 : 32'h8003);
        idle(2);

        // Reset mid-symbol discards buffer and partial bits
        sym_ready = 1'b0; width_cfg = 4'd1; msb_first = 1'b1;
        send_vec(32'b1101, 4);
        send(1'b1);
        bit_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("rst_mid_fill", 32'(fill), 32'd0);
        chk("rst_mid_ovr", 32'(overrun), 32'd0);
        rst = 1'b0;
        tick();
        sym_ready = 1'b1;
        send_vec(32'b01, 2);
        chk("post_rst_sym", 32'(sym_data), 32'h1);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/sym_packer.md
Name: sym_packer

Overview:
Parametrised successor to the serial-to-parallel converter. It accumulates a single-bit stream (e.g. m-sequence output) into symbols whose width is selectable at run time, with selectable bit order. Completed symbols are buffered in a small output FIFO with a valid/ready handshake and backpressure to the bit source. It sits between the bit source and the QAM symbol mapper.

Parameters:
MAX_W, 16, maximum symbol width in bits; width of sym_data.
CFG_W, 4, width of width_cfg; must satisfy 2**CFG_W >= MAX_W.
DEPTH, 4, output FIFO depth in symbols; power of two, >= 2.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset; asynchronous, active-high
bit_valid  in  1  input bit strobe; one bit accepted per cycle when bit_valid && bit_ready
bit_in  in  1  serial data bit
bit_ready  out  1  packer can accept a bit
width_cfg  in  CFG_W  symbol width minus 1 (0..MAX_W-1)
msb_first  in  1  1: first bit received lands in symbol MSB; 0: first bit lands in bit 0
sym_valid  out  1  FIFO head holds a symbol
sym_ready  in  1  consumer accepts head symbol
sym_data  out  MAX_W  FIFO head symbol, zero above active width
overrun  out  1  sticky: bit_valid seen while bit_ready low
fill  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset values: bit_ready=0 while rst is high, then 1 from the first clock after release; sym_valid=0, sym_data=0, overrun=0, fill=0. The accumulator, bit counter and FIFO pointers are all cleared.
- Reset asserted mid-symbol discards the partial symbol and all buffered symbols.
- Width latch: width_cfg and msb_first are captured into internal registers when the bit counter is 0 and a bit is accepted. Changes mid-symbol take effect on the next symbol.
- Accept: on each accepted bit the counter increments.
  - MSB-first: the accumulator shifts left, inserting the bit at bit 0.
  - LSB-first: the bit is written at index = counter.
- Completion: when the accepted bit is bit number W=latched_cfg+1, the completed symbol is written to the FIFO on that same edge.
  - Upper bits [MAX_W-1:W] are forced to 0.
  - The counter returns to 0 and the accumulator clears.
  - Latency from the last bit's edge to sym_valid=1 is 1 cycle.
- W=1 (width_cfg=0): every accepted bit produces a symbol.
- bit_ready = !(fill==DEPTH). A full FIFO stalls input, including mid-symbol.
- Pop: on sym_valid && sym_ready the head advances and sym_data shows the next entry on the following cycle; sym_data is registered from FIFO storage.
- Simultaneous push and pop: fill unchanged. Push while fill==DEPTH is impossible because bit_ready=0. Pop at fill==0 is ignored.
- Pointers wrap modulo DEPTH.
- overrun sets on bit_valid && !bit_ready and is cleared only by rst. The stalled bit is not consumed, so the source must hold it.
- A bit accepted in the same cycle sym_ready frees a slot from full is not allowed: bit_ready is evaluated from current fill only.

Optional Feature:
GRAY_MAP_EN. When defined, each completed symbol is Gray-encoded before the FIFO write: g = s ^ (s >> 1), computed over the active W bits only, with upper bits still 0. When undefined, symbols are stored as received (natural binary). Latency is identical either way.

Decomposition:
- Package sym_packer_pkg holds:
  - the FIFO pointer-width function (clog2 wrapper);
  - the constant MAX_W_DEFAULT=16;
  - a gray_encode function parametrised on width.
- One sub-module is natural: sync_fifo_reg (registered-output synchronous FIFO with fill count, parameters WIDTH and DEPTH), reusable by the mapper.

Test Plan:
- Reset: hold rst 5 cycles with bit_valid=1, then release. Required: all outputs 0 during reset; bit_ready=1 on the first cycle after; overrun stays 0 because bit_ready is low only during rst.
- MSB-first, width_cfg=3, bits 1,0,1,1 on consecutive cycles, sym_ready=1. Required: sym_valid one cycle after the 4th bit, sym_data=0x000B, held one cycle.
- LSB-first, width_cfg=3, bits 1,0,1,1. Required: sym_data=0x000D. Then width_cfg=0 with bits 1,0. Required: two symbols, 0x0001 then 0x0000.
- Backpressure: DEPTH=4, width_cfg=1, sym_ready=0, stream 10 bits. Required:
  - fill reaches 4 after 8 bits and bit_ready drops;
  - holding bit_valid sets overrun;
  - raising sym_ready drains four symbols in order with no loss.
- Mid-symbol config change: after 2 of 4 bits, set width_cfg=7. Required: the current symbol completes at 4 bits, and the next symbol needs 8 bits.
- GRAY_MAP_EN defined, MSB-first, width_cfg=3, input 0xB. Required: sym_data=0xE. Without the macro: sym_data=0xB.
